// File: rtl/counter_array_if.sv
// Register bus for counter_array: single-cycle write/read strobes, byte address, 32-bit data.
interface counter_array_if;
  logic        wr_en;
  logic        rd_en;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/counter_array.sv
// NUM_CH register-controlled up-counters with compare, wrap/one-shot, sticky W1C status and irq.
// Writes take effect at the strobe edge, rdata one cycle after rd_en; the bus never stalls.
module counter_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_array_if.slave    bus,
  output logic [NUM_CH-1:0] overflow,
  output logic              irq
);
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CMP  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic [NUM_CH-1:0] start, mode, irq_en, ovf, done, pending;
  logic [CNT_W-1:0]  cmp [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];

  logic       ch_region, glb_hit;
  logic [3:0] ch_idx;
  logic [1:0] reg_sel;
  logic [31:0] rd_val;
  logic       unused_bits;

  assign ch_region   = bus.addr[9:8] == 2'b00;
  assign glb_hit     = bus.addr[9:2] == 8'h40;
  assign ch_idx      = bus.addr[7:4];
  assign reg_sel     = bus.addr[3:2];
  assign pending     = irq_en & (ovf | done);
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [3:0] CH_ID = 4'(g);
    logic             sel, wr_ctrl, wr_cmp, wr_stat, clr, term;
    logic             start_r, mode_r, irq_en_r, ovf_r, done_r, pulse_r;
    logic [CNT_W-1:0] cmp_r, cnt_r;

    assign sel     = bus.wr_en && ch_region && (ch_idx == CH_ID);
    assign wr_ctrl = sel && (reg_sel == REG_CTRL);
    assign wr_cmp  = sel && (reg_sel == REG_CMP);
    assign wr_stat = sel && (reg_sel == REG_STAT);
    assign clr     = wr_ctrl && bus.wdata[1];
    assign term    = cnt_r == cmp_r;

    // Statement order sets precedence: W1C < hardware set; hardware start-clear < software CTRL write.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        start_r  <= 1'b0;
        mode_r   <= 1'b0;
        irq_en_r <= 1'b0;
        ovf_r    <= 1'b0;
        done_r   <= 1'b0;
        pulse_r  <= 1'b0;
        cmp_r    <= '1;
        cnt_r    <= '0;
      end else begin
        pulse_r <= 1'b0;
        if (wr_stat) begin
          if (bus.wdata[0]) ovf_r  <= 1'b0;
          if (bus.wdata[1]) done_r <= 1'b0;
        end
        if (clr) begin
          cnt_r <= '0;
        end else if (start_r) begin
          if (!term) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (!mode_r) begin
            cnt_r   <= '0;
            ovf_r   <= 1'b1;
            pulse_r <= 1'b1;
          end else begin
            done_r  <= 1'b1;
            start_r <= 1'b0;
          end
        end
        if (wr_ctrl) begin
          start_r  <= bus.wdata[0];
          mode_r   <= bus.wdata[2];
          irq_en_r <= bus.wdata[3];
        end
        if (wr_cmp) cmp_r <= bus.wdata[CNT_W-1:0];
      end
    end

    assign start[g]    = start_r;
    assign mode[g]     = mode_r;
    assign irq_en[g]   = irq_en_r;
    assign ovf[g]      = ovf_r;
    assign done[g]     = done_r;
    assign overflow[g] = pulse_r;
    assign cmp[g]      = cmp_r;
    assign cnt[g]      = cnt_r;
  end

  always_comb begin
    rd_val = '0;
    if (glb_hit) begin
      rd_val = 32'(pending);
    end else if (ch_region) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (reg_sel)
            REG_CTRL: rd_val = {28'd0, irq_en[i], mode[i], 1'b0, start[i]};
            REG_CMP:  rd_val = 32'(cmp[i]);
            REG_CNT:  rd_val = 32'(cnt[i]);
            REG_STAT: rd_val = {30'd0, done[i], ovf[i]};
            default:  rd_val = '0;
          endcase
        end
      end
    end
  end

  // irq lags STAT by one cycle because it is registered from the status flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (bus.rd_en) bus.rdata <= rd_val;
      irq <= |pending;
    end
  end
endmodule

// File: tb/tb_counter_array.sv
// Directed bench for counter_array (NUM_CH=4, CNT_W=16); inputs driven and outputs sampled on negedge.
module tb_counter_array;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] overflow;
  logic       irq;
  logic [31:0] d;
  logic       seen;
  int         checks = 0;
  int         errors = 0;

  counter_array_if bus ();

  counter_array #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .overflow (overflow),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] v);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] v);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    v = bus.rdata;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    // Reset while ch3 is counting
    wr(10'h030, 32'h1);
    repeat (5) @(negedge clk);
    rd(10'h034, d); check("pre_rst_cmp", d, 32'h0000_FFFF);
    rd(10'h038, d); check("pre_rst_cnt", d, 32'd6);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rdata", bus.rdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    rd(10'h038, d); check("rst_cnt3", d, 32'h0);
    rd(10'h034, d); check("rst_cmp3", d, 32'h0000_FFFF);
    rd(10'h030, d); check("rst_ctrl3", d, 32'h0);

    // Wrap mode, ch0, CMP=3
    wr(10'h004, 32'd3);
    wr(10'h000, 32'h9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("wrap_ovfpulse%0d", k), 32'(overflow[0]), (k == 4 || k == 8) ? 32'd1 : 32'd0);
      rd(10'h008, d);
      check($sformatf("wrap_cnt%0d", k), d, 32'(k % 4));
    end
    check("wrap_irq", 32'(irq), 32'h1);
    rd(10'h00C, d); check("wrap_stat", d, 32'h1);
    wr(10'h00C, 32'h1);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("w1c_irq_low", 32'(irq), 32'h0);
    @(negedge clk);
    check("rewrap_irq", 32'(irq), 32'h1);

    // W1C on the same edge as a wrap
    repeat (2) @(negedge clk);
    wr(10'h00C, 32'h1);
    check("coll_pulse", 32'(overflow[0]), 32'h1);
    rd(10'h00C, d); check("coll_stat", d, 32'h1);
    wr(10'h000, 32'h8);
    wr(10'h00C, 32'h1);

    // One-shot, ch1, CMP=5
    wr(10'h014, 32'd5);
    wr(10'h010, 32'hD);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= overflow[1];
    end
    rd(10'h018, d); check("os_cnt_mid", d, 32'd3);
    repeat (8) begin
      seen |= overflow[1];
      @(negedge clk);
    end
    check("os_no_pulse", 32'(seen), 32'h0);
    rd(10'h018, d); check("os_cnt_hold", d, 32'd5);
    rd(10'h01C, d); check("os_stat", d, 32'h2);
    rd(10'h010, d); check("os_ctrl", d, 32'hC);

    // Clear wins over terminal action, ch2, CMP=4
    wr(10'h024, 32'd4);
    wr(10'h020, 32'h1);
    repeat (4) @(negedge clk);
    wr(10'h020, 32'h3);
    check("clr_no_pulse", 32'(overflow[2]), 32'h0);
    rd(10'h028, d); check("clr_cnt0", d, 32'd0);
    rd(10'h028, d); check("clr_cnt1", d, 32'd1);
    rd(10'h028, d); check("clr_cnt2", d, 32'd2);
    rd(10'h02C, d); check("clr_stat", d, 32'h0);
    wr(10'h020, 32'h0);

    // Decode: unmapped and read-only locations
    rd(10'h044, d); check("unmap_ch4", d, 32'h0);
    rd(10'h3FC, d); check("unmap_3fc", d, 32'h0);
    wr(10'h044, 32'h1234);
    wr(10'h040, 32'h1);
    wr(10'h3FC, 32'hFFFF_FFFF);
    wr(10'h018, 32'h0);
    rd(10'h004, d); check("dec_cmp0", d, 32'd3);
    rd(10'h000, d); check("dec_ctrl0", d, 32'h8);
    rd(10'h040, d); check("dec_ch4_rd", d, 32'h0);
    rd(10'h018, d); check("dec_cnt_ro", d, 32'd5);
    rd(10'h100, d); check("glb_ch1", d, 32'h2);

    // CMP=0 wrap mode, ch3: continuous overflow
    wr(10'h034, 32'h0);
    wr(10'h030, 32'h9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("cmp0_pulse%0d", k), 32'(overflow[3]), 32'h1);
    end
    rd(10'h038, d); check("cmp0_cnt", d, 32'h0);
    rd(10'h100, d); check("glb_ch1_ch3", d, 32'hA);
    check("glb_irq", 32'(irq), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
